prefetch_buffer: RTL and testbench
==================================

# prefetch_buffer

Instruction prefetch stage sitting directly upstream of the single-cycle core's decode/execute datapath. Issues sequential word fetches to instruction memory over a request/grant/response handshake and buffers returned instructions with their PCs in a small FIFO. Presents them to the core over valid/ready. Accepts a redirect (taken branch, jal, jalr) that flushes the buffer, discards in-flight responses and restarts fetch at the new PC.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2; also bounds outstanding requests
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  input  1  rising-edge clock
- n_rst  input  1  asynchronous active-low reset
- imem_req  output  1  fetch request valid
- imem_addr  output  32  fetch word address, always 4-byte aligned
- imem_gnt  input  1  memory accepts request this cycle
- imem_rvalid  input  1  response data valid; responses return in order, ≥1 cycle after grant
- imem_rdata  input  32  instruction word
- instr_valid  output  1  head entry valid
- instr  output  32  head instruction
- instr_pc  output  32  PC of head instruction
- instr_ready  input  1  core consumes head this cycle
- redirect_valid  input  1  flush and restart fetch
- redirect_pc  input  32  new fetch PC
- misalign_err  output  1  sticky redirect-misalignment flag (see Configuration)

## Operation
- State: fetch_pc (next address to request), resp_pc (PC of next kept response), FIFO of {pc, instr} with occ count, outst (all in-flight requests), discard (in-flight responses to drop, discard ≤ outst), started flag.
- started: 0 in reset, 1 from first clock after reset release; imem_req held low while 0.
- imem_req = started & !redirect_valid & (occ + outst < DEPTH); imem_addr = fetch_pc.
- imem_req & imem_gnt: fetch_pc += 4 (wraps mod 2^32), outst += 1.
- imem_rvalid: outst -= 1; if discard > 0, drop word, discard -= 1; else push {resp_pc, imem_rdata}, resp_pc += 4.
- instr_valid = (occ != 0); instr/instr_pc = head entry. instr_valid & instr_ready pops.
- Simultaneous push and pop: occ unchanged. Push on full cannot occur (budget rule); assertion-checked.
- Redirect (cycle N): FIFO cleared (occ=0), any pop ignored; fetch_pc and resp_pc ← {redirect_pc[31:2], 2'b00}; discard ← outst − imem_rvalid (response in cycle N also dropped); no request issued in cycle N.
- Back-to-back redirects: last one wins; discard accumulates correctly since outst counts everything in flight.
- Reset mid-operation: all state cleared immediately; responses to pre-reset requests are the memory's responsibility (memory is reset too).

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, instr_valid 0, instr 0, instr_pc 0, misalign_err 0; fetch_pc = resp_pc = RESET_PC, occ = outst = discard = 0.
- First request: cycle 1 after n_rst rises (started set).
- No bypass: rvalid in cycle N → instr_valid in N+1.
- Redirect at N with zero-wait memory (gnt same cycle, rvalid next): req N+1, rvalid N+2, instr_valid N+3.
- Sustained throughput 1 instr/cycle once rvalid latency ≤ DEPTH−1 cycles.

## Configuration
- PREFETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0] != 0 sets misalign_err (sticky until reset); fetch still proceeds from the word-aligned address.
- Not defined: redirect_pc[1:0] silently ignored; misalign_err tied 0.

## Test plan
- Reset release, zero-wait memory returning rdata = addr: requests at 0x0,0x4,0x8…; instr_valid from cycle 3; instr/instr_pc pairs (0x0,0x0),(0x4,0x4) with instr_ready=1 every cycle.
- instr_ready=0 held, DEPTH=4: exactly 4 grants, imem_req drops, occ=4; release ready → 4 pops in order, fetch resumes next cycle.
- 3 requests outstanding (memory latency 3) then redirect_pc=0x100: next 3 rvalids dropped, first instr_pc = 0x100, no stale entry visible.
- Redirect coinciding with rvalid and instr_valid&instr_ready: that response dropped, FIFO empty next cycle, discard = outst−1.
- Redirects at consecutive cycles to 0x200 then 0x300: only 0x300 stream appears.
- With PREFETCH_ALIGN_CHECK_EN, redirect_pc=0x102: misalign_err=1 and stays 1, fetch at 0x100; without macro misalign_err stays 0.

Source files
------------

// File: rtl/prefetch_buffer_if.sv
// prefetch_buffer_if: instruction-memory fetch bus and core-side stream.
// master = prefetch buffer side, slave = memory/core environment side.
interface prefetch_buffer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        misalign_err;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      output instr_valid, instr, instr_pc,
      input  instr_ready, redirect_valid, redirect_pc,
      output misalign_err
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      input  instr_valid, instr, instr_pc,
      output instr_ready, redirect_valid, redirect_pc,
      input  misalign_err
   );
endinterface

// File: rtl/prefetch_buffer.sv
// prefetch_buffer: sequential instruction prefetch with a {pc,instr} FIFO.
// Ports: clk, n_rst (async low), bus (prefetch_buffer_if.master).
// PREFETCH_ALIGN_CHECK_EN: flag misaligned redirect targets in misalign_err.
module prefetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic               clk,
   input logic               n_rst,
   prefetch_buffer_if.master bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef logic [CW-1:0] cnt_t;

   logic          started_q, started_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   cnt_t          occ_q, occ_d;
   cnt_t          outst_q, outst_d;
   cnt_t          disc_q, disc_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic          mis_q, mis_d;
   logic [31:0]   pc_mem_q  [DEPTH];
   logic [31:0]   ins_mem_q [DEPTH];

   logic          flush;
   logic [31:0]   tgt_pc;
   logic [CW:0]   budget;
   logic          req;
   logic          fire;
   logic          keep;
   logic          push;
   logic          pop;

   always_comb begin
      flush  = bus.redirect_valid;
      tgt_pc = bus.redirect_pc & 32'hFFFF_FFFC;
      // Slots already promised (buffered + in flight) bound new requests,
      // so a returning word always has a FIFO entry waiting for it.
      budget = {1'b0, occ_q} + {1'b0, outst_q};
      req    = started_q & ~flush & (budget < (CW+1)'(DEPTH));
      fire   = req & bus.imem_gnt;
      keep   = bus.imem_rvalid & (disc_q == '0);
      push   = keep & ~flush;
      pop    = (occ_q != '0) & bus.instr_ready & ~flush;
   end

   always_comb begin
      started_d  = 1'b1;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      occ_d      = occ_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      outst_d    = outst_q + cnt_t'(fire) - cnt_t'(bus.imem_rvalid);
      disc_d     = disc_q;
      if (flush) begin
         fetch_pc_d = tgt_pc;
         resp_pc_d  = tgt_pc;
         occ_d      = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         // Everything still in flight is stale, including a word
         // arriving right now.
         disc_d     = outst_q - cnt_t'(bus.imem_rvalid);
      end else begin
         if (fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         occ_d = occ_q + cnt_t'(push) - cnt_t'(pop);
         if (bus.imem_rvalid && disc_q != '0) disc_d = disc_q - 1'b1;
      end
   end

   always_comb begin
`ifdef PREFETCH_ALIGN_CHECK_EN
      mis_d = mis_q | (flush & (bus.redirect_pc[1:0] != 2'b00));
`else
      mis_d = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         started_q  <= 1'b0;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         occ_q      <= '0;
         outst_q    <= '0;
         disc_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         mis_q      <= 1'b0;
      end else begin
         started_q  <= started_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         occ_q      <= occ_d;
         outst_q    <= outst_d;
         disc_q     <= disc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         mis_q      <= mis_d;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_mem_q[i]  <= '0;
            ins_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q]  <= resp_pc_q;
         ins_mem_q[wr_ptr_q] <= bus.imem_rdata;
      end
   end

   assign bus.imem_req     = req;
   assign bus.imem_addr    = fetch_pc_q;
   assign bus.instr_valid  = (occ_q != '0);
   assign bus.instr        = ins_mem_q[rd_ptr_q];
   assign bus.instr_pc     = pc_mem_q[rd_ptr_q];
   assign bus.misalign_err = mis_q;

   a_no_push_full : assert property (
      @(posedge clk) disable iff (!n_rst)
      !(push && occ_q == cnt_t'(DEPTH))
   );

   a_no_orphan_rsp : assert property (
      @(posedge clk) disable iff (!n_rst)
      !(bus.imem_rvalid && outst_q == '0)
   );

endmodule

// File: tb/tb_prefetch_buffer.sv
// tb_prefetch_buffer: scoreboard bench with an in-order memory model
// and an expected instruction stream regenerated at every redirect.
module tb_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  prefetch_buffer_if bus ();

  prefetch_buffer #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  ent_t        exp_q[$];
  rsp_t        pend[$];
  ent_t        mon_e;
  logic [31:0] gen_pc;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          grants = 0;
  int          pops = 0;
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        exp_mis = 1'b0;
  logic        prev_redir = 1'b0;
  logic        align_chk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void check(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void restart(input logic [31:0] pc);
    exp_q.delete();
    gen_pc = pc & 32'hFFFF_FFFC;
  endfunction

  function automatic void topup();
    while (exp_q.size() < 32) begin
      exp_q.push_back('{gen_pc, mem_word(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
  endfunction

  task automatic step(input logic rdy, input logic redir,
                      input logic [31:0] rpc);
    @(negedge clk);
    cyc++;
    bus.instr_ready    = rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
    bus.imem_gnt = (int'($urandom_range(99)) < gnt_pct);
    if (redir) restart(rpc);
    topup();
    #1;
    if (prev_redir) check("misalign_err", {31'd0, bus.misalign_err}, {31'd0, exp_mis});
    if (redir && align_chk && rpc[1:0] != 2'b00) exp_mis = 1'b1;
    prev_redir = redir;
    if (bus.imem_req && bus.imem_gnt) begin
      grants++;
      pend.push_back('{bus.imem_addr,
                       cyc + int'($urandom_range(lat_max, lat_min))});
      check("addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
      check("outst_bound", {31'd0, pend.size() > DEPTH}, 32'd0);
    end
    if (bus.instr_valid && rdy && !redir) pops++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    pend.delete();
    restart(RESET_PC);
    topup();
    exp_mis    = 1'b0;
    prev_redir = 1'b0;
    #1;
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_addr", bus.imem_addr, RESET_PC);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_pc", bus.instr_pc, 32'd0);
    check("rst_mis", {31'd0, bus.misalign_err}, 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    cyc   = 0;
    #1;
    check("req_cycle0", {31'd0, bus.imem_req}, 32'd0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (n_rst && bus.instr_valid && bus.instr_ready
          && !bus.redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_empty: got pc %h want none", bus.instr_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("instr_pc", bus.instr_pc, mon_e.pc);
          check("instr", bus.instr, mon_e.ins);
        end
      end
    end
  end

  initial begin : stim
    int p0;
    int g0;
    logic hit;
`ifdef PREFETCH_ALIGN_CHECK_EN
    align_chk = 1'b1;
`else
    align_chk = 1'b0;
`endif
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;

    // zero-wait startup and throughput
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    step(1'b1, 1'b0, '0);
    check("c1_req", {31'd0, bus.imem_req}, 32'd1);
    check("c1_addr", bus.imem_addr, RESET_PC);
    step(1'b1, 1'b0, '0);
    check("c2_addr", bus.imem_addr, RESET_PC + 32'd4);
    check("c2_valid", {31'd0, bus.instr_valid}, 32'd0);
    step(1'b1, 1'b0, '0);
    check("c3_valid", {31'd0, bus.instr_valid}, 32'd1);
    p0 = pops;
    repeat (20) step(1'b1, 1'b0, '0);
    check("throughput", pops - p0, 32'd20);

    // redirect coinciding with rvalid and a pop
    step(1'b1, 1'b1, 32'h0000_0040);
    check("rd_coinc_rvalid", {31'd0, bus.imem_rvalid}, 32'd1);
    check("rd_coinc_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("rd_no_req", {31'd0, bus.imem_req}, 32'd0);
    step(1'b1, 1'b0, '0);
    check("rd_n1_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rd_n1_req", {31'd0, bus.imem_req}, 32'd1);
    check("rd_n1_addr", bus.imem_addr, 32'h0000_0040);
    step(1'b1, 1'b0, '0);
    check("rd_n2_valid", {31'd0, bus.instr_valid}, 32'd0);
    step(1'b1, 1'b0, '0);
    check("rd_n3_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("rd_n3_pc", bus.instr_pc, 32'h0000_0040);
    repeat (5) step(1'b1, 1'b0, '0);

    // back-to-back redirects, then address wrap
    step(1'b1, 1'b1, 32'h0000_0200);
    step(1'b1, 1'b1, 32'h0000_0300);
    step(1'b1, 1'b0, '0);
    check("b2b_addr", bus.imem_addr, 32'h0000_0300);
    repeat (10) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (10) step(1'b1, 1'b0, '0);

    // redirect with several requests in flight
    lat_min = 3; lat_max = 3;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1'b1, 1'b0, '0);
      if (pend.size() >= 3) hit = 1'b1;
    end
    check("three_in_flight", {31'd0, hit}, 32'd1);
    step(1'b1, 1'b1, 32'h0000_0100);
    repeat (15) step(1'b1, 1'b0, '0);

    // backpressure fills the FIFO and stops fetch
    lat_min = 1; lat_max = 1;
    do_reset();
    g0 = grants;
    repeat (10) step(1'b0, 1'b0, '0);
    check("full_grants", grants - g0, 32'd4);
    check("full_req", {31'd0, bus.imem_req}, 32'd0);
    check("full_valid", {31'd0, bus.instr_valid}, 32'd1);
    p0 = pops;
    step(1'b1, 1'b0, '0);
    check("drain_req0", {31'd0, bus.imem_req}, 32'd0);
    step(1'b1, 1'b0, '0);
    check("drain_req1", {31'd0, bus.imem_req}, 32'd1);
    repeat (2) step(1'b1, 1'b0, '0);
    check("drain_pops", pops - p0, 32'd4);

    // misaligned redirect target
    check("mis_before", {31'd0, bus.misalign_err}, 32'd0);
    step(1'b1, 1'b1, 32'h0000_0102);
    step(1'b1, 1'b0, '0);
    check("mis_addr", bus.imem_addr, 32'h0000_0100);
    check("mis_flag", {31'd0, bus.misalign_err}, {31'd0, align_chk});
    repeat (6) step(1'b1, 1'b0, '0);
    check("mis_sticky", {31'd0, bus.misalign_err}, {31'd0, align_chk});

    // randomized traffic with a mid-run reset
    gnt_pct = 70; lat_min = 1; lat_max = 4;
    for (int pass = 0; pass < 2; pass++) begin
      p0 = pops;
      for (int i = 0; i < 800; i++)
        step($urandom_range(99) < 70, $urandom_range(99) < 3,
             $urandom & 32'h0003_FFFF);
      check("liveness", {31'd0, (pops - p0) > 150}, 32'd1);
      check("rand_mis", {31'd0, bus.misalign_err}, {31'd0, exp_mis});
      if (pass == 0) do_reset();
    end

    repeat (3) step(1'b0, 1'b0, '0);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
